cascade_counter: RTL and testbench
==================================

Name: cascade_counter

Overview:
- Parametrised multi-digit up/down counter built from a chain of per-digit counters, each with its own runtime limit.
- Each digit passes a carry or borrow to the next digit up.
- Adds direction control, parallel load, a wrap/saturate option and terminal flags.
- Feeds countdown timers, stopwatches and clocks (e.g. a mm:ss display) ahead of the seven-segment driver.

Parameters:
NUM_DIGITS, 4, number of cascaded digits; digit 0 is least significant
DIGIT_W, 4, bits per digit
WRAP_EN, 1, 1 = wrap at the terminal value; 0 = saturate at the terminal value

Ports:
clk  input  1  global clock
rst  input  1  synchronous active-high reset
en  input  1  single-cycle count strobe; counter steps once per cycle en=1
dir  input  1  0 = count down, 1 = count up
load  input  1  parallel load strobe
load_value  input  NUM_DIGITS*DIGIT_W  value written on load; digit i at [i*DIGIT_W +: DIGIT_W]
init_value  input  NUM_DIGITS*DIGIT_W  value taken on reset
limit  input  NUM_DIGITS*DIGIT_W  per-digit maximum (e.g. 9 or 5)
value  output  NUM_DIGITS*DIGIT_W  registered counter state
carry_out  output  1  combinational; full-counter up wrap this cycle
borrow_out  output  1  combinational; full-counter down wrap this cycle
at_zero  output  1  combinational; all digits = 0
at_max  output  1  combinational; every digit = its limit

Behaviour:
- Register priority at each rising clk edge: rst > load > en > hold.
- rst=1: value <= init_value. Flags follow value combinationally; there are no other registers.
- load=1 (rst=0): value <= load_value; en ignored that cycle; carry_out=borrow_out=0.
- Digit i steps when en=1 and every lower digit is at its boundary for the current direction.
  - Down boundary: digit = 0.
  - Up boundary: digit = limit_i.
  - Digit 0 steps whenever en=1.
- Down step: digit = 0 -> limit_i, and borrow to digit i+1; otherwise digit - 1.
- Up step: digit >= limit_i -> 0, and carry to digit i+1; an out-of-range digit therefore recovers on the next up step. Otherwise digit + 1.
- Out-of-range digit on a down step: normal decrement, no clamp.
- Inter-digit carry/borrow is combinational, so the whole chain updates in one cycle. Latency from en to new value is 1 clk.
- borrow_out = en & ~dir & at_zero & ~load & ~rst.
- carry_out = en & dir & at_max & ~load & ~rst.
- Both strobes are valid in the same cycle as the en that causes the wrap.
- WRAP_EN=1: all-zero down -> every digit at its limit; all-max up -> all zero.
- WRAP_EN=0: when the wrap condition holds, value holds.
  - carry_out/borrow_out are forced to 0.
  - at_zero/at_max remain asserted, so the consumer uses them as "done".
- dir change between strobes takes effect on the next en; no state is kept across a direction change.
- limit changes take effect immediately. A digit above a new, lower limit is handled by the out-of-range rules above.
- rst mid-count: the next edge gives init_value regardless of en/load.

Decomposition:
- Shared package cascade_counter_pkg holds:
  - DIR_DOWN = 1'b0, DIR_UP = 1'b1
  - the default DIGIT_W
  - a function slicing digit i from a packed bus
- One sub-module, counter_digit, parametrised by DIGIT_W.
  - Inputs: clk, rst, step, dir, load, load_digit, init_digit, limit_digit.
  - Outputs: digit value, at_low (digit = 0), at_high (digit >= limit).
- The top level instantiates NUM_DIGITS copies with a generate loop and builds the step chain, the terminal flags and the WRAP_EN gating.

Test Plan:
1. NUM_DIGITS=2, limit=0x59, init_value=0x30; assert rst 1 cycle -> value=0x30, at_zero=0, at_max=0.
2. Down count: value=0x10, dir=0, en pulse -> 0x09, borrow_out=0. Then load 0x00 and en -> 0x59, borrow_out=1 for exactly that cycle.
3. Up count: load 0x58, dir=1, en, en -> 0x59 (at_max=1), then 0x00 with carry_out=1 on the second en cycle only.
4. Same cycle load=1 with value 0x37 and en=1 -> 0x37 with no step. The next en with dir=0 -> 0x36.
5. WRAP_EN=0: value 0x00, dir=0, en for 3 cycles -> value stays 0x00, borrow_out=0, at_zero=1 throughout. Repeat for up at 0x59 -> holds, carry_out=0.
6. Reset mid-operation and out-of-range digit:
   - rst asserted together with load=1 (0x44) and en=1 -> value=init_value (0x30).
   - Then load 0x0C (digit 0 above limit 9), dir=1, en -> 0x10.

Source files
------------

// File: rtl/cascade_counter_pkg.sv
// Shared constants and helpers for the cascaded digit counter.
package cascade_counter_pkg;

  localparam logic DIR_DOWN = 1'b0;
  localparam logic DIR_UP   = 1'b1;

  localparam int unsigned DEFAULT_DIGIT_W = 4;
  localparam int unsigned MAX_BUS_W       = 64;
  localparam int unsigned MAX_DIGIT_W     = 16;

  // Extract digit idx of width w from a packed bus, zero-extended to MAX_DIGIT_W.
  function automatic logic [MAX_DIGIT_W-1:0] digit_slice(input logic [MAX_BUS_W-1:0] bus,
                                                         input int unsigned        idx,
                                                         input int unsigned        w);
    logic [MAX_BUS_W-1:0] mask;
    mask = (MAX_BUS_W'(1) << w) - MAX_BUS_W'(1);
    return MAX_DIGIT_W'((bus >> (idx * w)) & mask);
  endfunction

endpackage

// File: rtl/cascade_counter_digit.sv
// Single digit of the cascade: wraps between 0 and its limit when stepped.
module counter_digit
  import cascade_counter_pkg::*;
#(
  parameter int unsigned DIGIT_W = DEFAULT_DIGIT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               step,
  input  logic               dir,
  input  logic               load,
  input  logic [DIGIT_W-1:0] load_digit,
  input  logic [DIGIT_W-1:0] init_digit,
  input  logic [DIGIT_W-1:0] limit_digit,
  output logic [DIGIT_W-1:0] digit,
  output logic               at_low,
  output logic               at_high
);

  assign at_low  = (digit == '0);
  // >= so an out-of-range digit rolls to 0 on the next up step
  assign at_high = (digit >= limit_digit);

  always_ff @(posedge clk) begin
    if (rst) begin
      digit <= init_digit;
    end else if (load) begin
      digit <= load_digit;
    end else if (step) begin
      if (dir == DIR_UP) begin
        digit <= at_high ? '0 : digit + DIGIT_W'(1);
      end else begin
        digit <= at_low ? limit_digit : digit - DIGIT_W'(1);
      end
    end
  end

endmodule

// File: rtl/cascade_counter.sv
// Multi-digit up/down counter: chain of per-digit counters with combinational carry/borrow.
module cascade_counter
  import cascade_counter_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned DIGIT_W    = DEFAULT_DIGIT_W,
  parameter bit          WRAP_EN    = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic                          dir,
  input  logic                          load,
  input  logic [NUM_DIGITS*DIGIT_W-1:0] load_value,
  input  logic [NUM_DIGITS*DIGIT_W-1:0] init_value,
  input  logic [NUM_DIGITS*DIGIT_W-1:0] limit,
  output logic [NUM_DIGITS*DIGIT_W-1:0] value,
  output logic                          carry_out,
  output logic                          borrow_out,
  output logic                          at_zero,
  output logic                          at_max
);

  logic [NUM_DIGITS-1:0] at_low;
  logic [NUM_DIGITS-1:0] at_high;
  logic [NUM_DIGITS-1:0] at_lim;
  logic [NUM_DIGITS-1:0] step;
  logic                  strobe;
  logic                  hold;
  logic                  active;

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    logic [DIGIT_W-1:0] digit_q;
    logic [DIGIT_W-1:0] lim_d;

    assign lim_d = DIGIT_W'(digit_slice(MAX_BUS_W'(limit), i, DIGIT_W));

    counter_digit #(
      .DIGIT_W(DIGIT_W)
    ) u_digit (
      .clk        (clk),
      .rst        (rst),
      .step       (step[i]),
      .dir        (dir),
      .load       (load),
      .load_digit (DIGIT_W'(digit_slice(MAX_BUS_W'(load_value), i, DIGIT_W))),
      .init_digit (DIGIT_W'(digit_slice(MAX_BUS_W'(init_value), i, DIGIT_W))),
      .limit_digit(lim_d),
      .digit      (digit_q),
      .at_low     (at_low[i]),
      .at_high    (at_high[i])
    );

    assign at_lim[i]                       = (digit_q == lim_d);
    assign value[i*DIGIT_W +: DIGIT_W]     = digit_q;
  end

  assign at_zero = &at_low;
  assign at_max  = &at_lim;

  // Saturating mode freezes the whole counter at the terminal value for the current direction.
  assign hold   = (WRAP_EN == 1'b0) && ((dir == DIR_UP) ? at_max : at_zero);
  assign strobe = en & ~load & ~rst;
  assign active = strobe & ~hold;

  assign carry_out  = strobe & (dir == DIR_UP)   & at_max  & WRAP_EN;
  assign borrow_out = strobe & (dir == DIR_DOWN) & at_zero & WRAP_EN;

  // Digit i steps when every lower digit sits at its boundary for the current direction.
  always_comb begin
    logic up_run;
    logic dn_run;
    step   = '0;
    up_run = 1'b1;
    dn_run = 1'b1;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      step[i] = active & ((dir == DIR_UP) ? up_run : dn_run);
      up_run  = up_run & at_high[i];
      dn_run  = dn_run & at_low[i];
    end
  end

endmodule

// File: tb/tb_cascade_counter.sv
// Self-checking bench for cascade_counter: directed table, saturate sequences, random vs model.
module tb_cascade_counter;

  logic       clk = 1'b0;
  logic       rst, en, dir, load;
  logic [7:0] load_value, init_value, limit;
  logic [7:0] value_w, value_s;
  logic       co_w, bo_w, az_w, am_w;
  logic       co_s, bo_s, az_s, am_s;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] m_w, m_s;

  always #5 clk = ~clk;

  cascade_counter #(.NUM_DIGITS(2), .DIGIT_W(4), .WRAP_EN(1'b1)) dut_w (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .load(load),
    .load_value(load_value), .init_value(init_value), .limit(limit),
    .value(value_w), .carry_out(co_w), .borrow_out(bo_w), .at_zero(az_w), .at_max(am_w)
  );

  cascade_counter #(.NUM_DIGITS(2), .DIGIT_W(4), .WRAP_EN(1'b0)) dut_s (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .load(load),
    .load_value(load_value), .init_value(init_value), .limit(limit),
    .value(value_s), .carry_out(co_s), .borrow_out(bo_s), .at_zero(az_s), .at_max(am_s)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference: counter as a ripple of digits, each with its own modulus (limit+1).
  function automatic logic [7:0] mdl_next(input logic [7:0] v, input logic [7:0] lim, input bit wrap,
                                          input logic r, input logic l, input logic e, input logic d,
                                          input logic [7:0] lv, input logic [7:0] iv);
    logic [7:0] nv;
    logic [3:0] dg, li;
    bit         c;
    if (r) return iv;
    if (l) return lv;
    if (!e) return v;
    if (!wrap && (d ? (v == lim) : (v == 8'h00))) return v;
    nv = v;
    c  = 1'b1;
    for (int i = 0; i < 2; i++) begin
      if (c) begin
        dg = nv[i*4 +: 4];
        li = lim[i*4 +: 4];
        if (d) begin
          if (dg >= li) dg = 4'h0;
          else begin dg = dg + 4'h1; c = 1'b0; end
        end else begin
          if (dg == 4'h0) dg = li;
          else begin dg = dg - 4'h1; c = 1'b0; end
        end
        nv[i*4 +: 4] = dg;
      end
    end
    return nv;
  endfunction

  // One clock: drive inputs, check both DUTs against the model mid-cycle, advance the model.
  task automatic cyc(input logic r, input logic l, input logic e, input logic d, input logic [7:0] lv,
                     output logic cw, output logic bw, output logic cs, output logic bs);
    logic gate;
    rst = r; load = l; en = e; dir = d; load_value = lv;
    @(negedge clk);
    gate = e & ~l & ~r;
    check("val_w", 32'(value_w), 32'(m_w));
    check("az_w",  32'(az_w), 32'(m_w == 8'h00));
    check("am_w",  32'(am_w), 32'(m_w == limit));
    check("co_w",  32'(co_w), 32'(gate & d & (m_w == limit)));
    check("bo_w",  32'(bo_w), 32'(gate & ~d & (m_w == 8'h00)));
    check("val_s", 32'(value_s), 32'(m_s));
    check("az_s",  32'(az_s), 32'(m_s == 8'h00));
    check("am_s",  32'(am_s), 32'(m_s == limit));
    check("co_s",  32'(co_s), 32'(1'b0));
    check("bo_s",  32'(bo_s), 32'(1'b0));
    cw = co_w; bw = bo_w; cs = co_s; bs = bo_s;
    m_w = mdl_next(m_w, limit, 1'b1, r, l, e, d, lv, init_value);
    m_s = mdl_next(m_s, limit, 1'b0, r, l, e, d, lv, init_value);
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       r, l, e, d;
    logic [7:0] lv;
    logic       co, bo;
    logic [7:0] nv;
    logic       az, am;
  } vec_t;

  vec_t tbl[17];

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : main
    logic cw, bw, cs, bs;
    logic d_rand;

    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h30, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h09, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h59, 1'b0, 1'b1};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h59, 1'b0, 1'b1};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h58, 1'b0, 1'b0, 8'h58, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 8'h59, 1'b0, 1'b1};
    tbl[9]  = '{1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 1'b1, 1'b0, 8'h37, 1'b0, 1'b0, 8'h37, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h36, 1'b0, 1'b0};
    tbl[12] = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h44, 1'b0, 1'b0, 8'h30, 1'b0, 1'b0};
    tbl[13] = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h0C, 1'b0, 1'b0, 8'h0C, 1'b0, 1'b0};
    tbl[14] = '{1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0};
    tbl[15] = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h59, 1'b0, 1'b0, 8'h59, 1'b0, 1'b1};
    tbl[16] = '{1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 8'h30, 1'b0, 1'b0};

    init_value = 8'h30;
    limit      = 8'h59;
    rst = 1'b1; en = 1'b0; dir = 1'b0; load = 1'b0; load_value = 8'h00;
    @(posedge clk);
    #1;
    m_w = init_value;
    m_s = init_value;

    // Directed table on the wrapping instance
    for (int i = 0; i < 17; i++) begin
      cyc(tbl[i].r, tbl[i].l, tbl[i].e, tbl[i].d, tbl[i].lv, cw, bw, cs, bs);
      check($sformatf("tbl%0d_co", i), 32'(cw), 32'(tbl[i].co));
      check($sformatf("tbl%0d_bo", i), 32'(bw), 32'(tbl[i].bo));
      check($sformatf("tbl%0d_val", i), 32'(value_w), 32'(tbl[i].nv));
      check($sformatf("tbl%0d_az", i), 32'(az_w), 32'(tbl[i].az));
      check($sformatf("tbl%0d_am", i), 32'(am_w), 32'(tbl[i].am));
    end

    // Saturating instance holds at zero counting down
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, cw, bw, cs, bs);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, cw, bw, cs, bs);
      check("sat_dn_bo", 32'(bs), 32'(1'b0));
      check("sat_dn_val", 32'(value_s), 32'(8'h00));
      check("sat_dn_az", 32'(az_s), 32'(1'b1));
    end

    // Saturating instance holds at max counting up
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 8'h59, cw, bw, cs, bs);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, 1'b1, 1'b1, 8'h00, cw, bw, cs, bs);
      check("sat_up_co", 32'(cs), 32'(1'b0));
      check("sat_up_val", 32'(value_s), 32'(8'h59));
      check("sat_up_am", 32'(am_s), 32'(1'b1));
    end

    // Random traffic against the model, with occasional limit/init changes
    d_rand = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      logic       r, l, e;
      logic [7:0] lv;
      int unsigned sel;
      if ($urandom_range(0, 99) == 0) begin
        limit      = {4'($urandom_range(0, 15)), 4'($urandom_range(0, 15))};
        init_value = 8'($urandom);
      end
      if ($urandom_range(0, 19) == 0) d_rand = ~d_rand;
      r   = ($urandom_range(0, 49) == 0);
      l   = ($urandom_range(0, 9) == 0);
      e   = ($urandom_range(0, 9) < 7);
      sel = $urandom_range(0, 3);
      lv  = (sel == 0) ? limit : (sel == 1) ? 8'h00 : 8'($urandom);
      cyc(r, l, e, d_rand, lv, cw, bw, cs, bs);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
